// File: rtl/alu_scheduler_pkg.sv
// alu_scheduler_pkg: shared widths, RV32I opcodes, broadcast/operand/entry
// structs and the broadcast snoop helper for the ALU reservation station.
package alu_scheduler_pkg;

  localparam int DATA_WID    = 32;
  localparam int ADDR_WID    = 32;
  localparam int ROB_POS_WID = 4;
  localparam int RS_POS_WID  = 4;

  localparam logic [6:0] OPCODE_ARITH  = 7'b0110011;
  localparam logic [6:0] OPCODE_ARITHI = 7'b0010011;
  localparam logic [6:0] OPCODE_BR     = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  // One result broadcast (ALU or LSB).
  typedef struct packed {
    logic                   en;
    logic [ROB_POS_WID-1:0] pos;
    logic [DATA_WID-1:0]    val;
  } cdb_t;

  // One source operand: either a value (rdy=1) or the producing ROB tag.
  typedef struct packed {
    logic                   rdy;
    logic [ROB_POS_WID-1:0] tag;
    logic [DATA_WID-1:0]    val;
  } opnd_t;

  typedef struct packed {
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic                   funct7;
    opnd_t                  op1;
    opnd_t                  op2;
    logic [DATA_WID-1:0]    imm;
    logic [ADDR_WID-1:0]    pc;
    logic [ROB_POS_WID-1:0] rob_pos;
  } rs_entry_t;

  // Capture a broadcast into a waiting operand. ALU broadcast wins a tie.
  function automatic opnd_t snoop(input opnd_t o, input cdb_t alu, input cdb_t lsb);
    opnd_t r;
    r = o;
    if (!o.rdy) begin
      if (alu.en && alu.pos == o.tag) begin
        r.rdy = 1'b1;
        r.val = alu.val;
      end else if (lsb.en && lsb.pos == o.tag) begin
        r.rdy = 1'b1;
        r.val = lsb.val;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_scheduler_lowest_sel.sv
// rs_lowest_sel: lowest-set-bit priority encoder.
//   req   - request vector (N bits)
//   found - any bit of req set
//   idx   - index of lowest set bit (0 when none)
module rs_lowest_sel #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan downward so the lowest set bit is the last to write idx.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: reservation station + issue select for the single ALU.
//   clk, rst (sync, high), rdy (global enable), rollback (ROB flush)
//   disp_*   - dispatch of one decoded ALU-class instruction
//   alu_result*/lsb_result* - result broadcasts snooped for wakeup
//   full     - busy count >= RS_SIZE-1 (one slack entry for dispatcher lag)
//   alu_en + opcode..rob_pos - registered issue payload to the ALU
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int RS_SIZE  = 16,
  parameter int RS_POS_W = RS_POS_WID
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   disp_en,
  input  logic [6:0]             disp_opcode,
  input  logic [2:0]             disp_funct3,
  input  logic                   disp_funct7,
  input  logic                   disp_rs1_rdy,
  input  logic                   disp_rs2_rdy,
  input  logic [DATA_WID-1:0]    disp_rs1_val,
  input  logic [DATA_WID-1:0]    disp_rs2_val,
  input  logic [ROB_POS_WID-1:0] disp_rs1_tag,
  input  logic [ROB_POS_WID-1:0] disp_rs2_tag,
  input  logic [DATA_WID-1:0]    disp_imm,
  input  logic [ADDR_WID-1:0]    disp_pc,
  input  logic [ROB_POS_WID-1:0] disp_rob_pos,
  input  logic                   alu_result,
  input  logic [ROB_POS_WID-1:0] alu_result_rob_pos,
  input  logic [DATA_WID-1:0]    alu_result_val,
  input  logic                   lsb_result,
  input  logic [ROB_POS_WID-1:0] lsb_result_rob_pos,
  input  logic [DATA_WID-1:0]    lsb_result_val,
  output logic                   full,
  output logic                   alu_en,
  output logic [6:0]             opcode,
  output logic [2:0]             funct3,
  output logic                   funct7,
  output logic [DATA_WID-1:0]    val1,
  output logic [DATA_WID-1:0]    val2,
  output logic [DATA_WID-1:0]    imm,
  output logic [ADDR_WID-1:0]    pc,
  output logic [ROB_POS_WID-1:0] rob_pos
);

  rs_entry_t [RS_SIZE-1:0] ent;
  rs_entry_t [RS_SIZE-1:0] ent_wk;
  rs_entry_t               disp_ent;
  logic [RS_SIZE-1:0]      busy;
  logic [RS_SIZE-1:0]      free_vec;
  logic [RS_SIZE-1:0]      ready_vec;
  logic                    free_found, sel_found;
  logic [RS_POS_W-1:0]     free_idx, sel_idx;
  logic [RS_POS_W:0]       busy_cnt;
  cdb_t                    alu_cdb, lsb_cdb;
  logic                    flush;

  assign flush   = rst || rollback;
  assign alu_cdb = '{en: alu_result, pos: alu_result_rob_pos, val: alu_result_val};
  assign lsb_cdb = '{en: lsb_result, pos: lsb_result_rob_pos, val: lsb_result_val};

  // Readiness comes from registered state only, so a wakeup at this edge
  // cannot also issue at this edge.
  assign free_vec = ~busy;
  for (genvar i = 0; i < RS_SIZE; i++) begin : g_rdy
    assign ready_vec[i] = busy[i] & ent[i].op1.rdy & ent[i].op2.rdy;
  end

  rs_lowest_sel #(.N(RS_SIZE), .W(RS_POS_W)) u_free_sel (
    .req(free_vec), .found(free_found), .idx(free_idx)
  );

  rs_lowest_sel #(.N(RS_SIZE), .W(RS_POS_W)) u_ready_sel (
    .req(ready_vec), .found(sel_found), .idx(sel_idx)
  );

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++)
      busy_cnt = busy_cnt + (RS_POS_W + 1)'(busy[i]);
  end

  assign full = busy_cnt >= (RS_POS_W + 1)'(RS_SIZE - 1);

  // Wakeup of stored entries.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_wk[i] = ent[i];
      if (busy[i]) begin
        ent_wk[i].op1 = snoop(ent[i].op1, alu_cdb, lsb_cdb);
        ent_wk[i].op2 = snoop(ent[i].op2, alu_cdb, lsb_cdb);
      end
    end
  end

  // Incoming entry, with same-cycle broadcast bypass on its operands.
  always_comb begin
    disp_ent         = '0;
    disp_ent.opcode  = disp_opcode;
    disp_ent.funct3  = disp_funct3;
    disp_ent.funct7  = disp_funct7;
    disp_ent.op1     = snoop('{rdy: disp_rs1_rdy, tag: disp_rs1_tag, val: disp_rs1_val},
                             alu_cdb, lsb_cdb);
    disp_ent.op2     = snoop('{rdy: disp_rs2_rdy, tag: disp_rs2_tag, val: disp_rs2_val},
                             alu_cdb, lsb_cdb);
    disp_ent.imm     = disp_imm;
    disp_ent.pc      = disp_pc;
    disp_ent.rob_pos = disp_rob_pos;
  end

  // Free and selected indices never coincide: one is busy, the other not.
  always_ff @(posedge clk) begin
    if (flush) begin
      busy <= '0;
    end else if (rdy) begin
      if (sel_found) busy[sel_idx] <= 1'b0;
      if (disp_en && free_found) busy[free_idx] <= 1'b1;
    end
  end

  // Entry payloads are meaningless while not busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!flush && rdy) begin
      ent <= ent_wk;
      if (disp_en && free_found) ent[free_idx] <= disp_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      alu_en  <= 1'b0;
      opcode  <= '0;
      funct3  <= '0;
      funct7  <= 1'b0;
      val1    <= '0;
      val2    <= '0;
      imm     <= '0;
      pc      <= '0;
      rob_pos <= '0;
    end else if (rdy) begin
      alu_en <= sel_found;
      if (sel_found) begin
        opcode  <= ent[sel_idx].opcode;
        funct3  <= ent[sel_idx].funct3;
        funct7  <= ent[sel_idx].funct7;
        val1    <= ent[sel_idx].op1.val;
        val2    <= ent[sel_idx].op2.val;
        imm     <= ent[sel_idx].imm;
        pc      <= ent[sel_idx].pc;
        rob_pos <= ent[sel_idx].rob_pos;
      end
    end
  end

  // Dispatching into a completely busy station drops the instruction.
  a_disp_when_full: assert property (@(posedge clk) disable iff (flush)
    !(rdy && disp_en && (&busy)));

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed self-checking bench for alu_scheduler.
module tb_alu_scheduler;
  import alu_scheduler_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst, rdy, rollback, disp_en;
  logic [6:0]             disp_opcode;
  logic [2:0]             disp_funct3;
  logic                   disp_funct7, disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0]            disp_rs1_val, disp_rs2_val, disp_imm, disp_pc;
  logic [ROB_POS_WID-1:0] disp_rs1_tag, disp_rs2_tag, disp_rob_pos;
  logic                   alu_result, lsb_result;
  logic [ROB_POS_WID-1:0] alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0]            alu_result_val, lsb_result_val;
  logic                   full, alu_en, funct7;
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [31:0]            val1, val2, imm, pc;
  logic [ROB_POS_WID-1:0] rob_pos;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_scheduler dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .disp_en(disp_en),
    .disp_opcode(disp_opcode), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_pos(disp_rob_pos),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val),
    .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
    .lsb_result_val(lsb_result_val),
    .full(full), .alu_en(alu_en), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .val1(val1), .val2(val2), .imm(imm), .pc(pc), .rob_pos(rob_pos)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; disp_en = 1'b0;
    disp_opcode = '0; disp_funct3 = '0; disp_funct7 = 1'b0;
    disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_val = '0; disp_rs2_val = '0;
    disp_rs1_tag = '0; disp_rs2_tag = '0; disp_imm = '0; disp_pc = '0; disp_rob_pos = '0;
    alu_result = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
    lsb_result = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;
  endtask

  task automatic disp(input logic [2:0] f3, input logic f7,
                      input logic r1r, input logic [31:0] r1v, input logic [3:0] r1t,
                      input logic r2r, input logic [31:0] r2v, input logic [3:0] r2t,
                      input logic [3:0] rob);
    disp_en = 1'b1; disp_opcode = OPCODE_ARITH; disp_funct3 = f3; disp_funct7 = f7;
    disp_rs1_rdy = r1r; disp_rs1_val = r1v; disp_rs1_tag = r1t;
    disp_rs2_rdy = r2r; disp_rs2_val = r2v; disp_rs2_tag = r2t;
    disp_imm = 32'h4; disp_pc = 32'h1000 + 32'(rob); disp_rob_pos = rob;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", full); end
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL reset_alu_en got=%0h exp=0", alu_en); end
    checks++; if ({opcode, funct3, funct7, val1, val2, imm, pc, rob_pos} !== '0) begin
      failures++; $display("FAIL reset_payload got val1=%0h val2=%0h pc=%0h rob=%0h exp=0", val1, val2, pc, rob_pos); end
  endtask

  task automatic test_ready_dispatch();
    disp(3'b000, 1'b0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
    tick(); idle();
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL add_early got=%0h exp=0", alu_en); end
    tick();
    checks++; if (alu_en !== 1'b1) begin failures++; $display("FAIL add_alu_en got=%0h exp=1", alu_en); end
    checks++; if (val1 !== 32'd5 || val2 !== 32'd7) begin failures++; $display("FAIL add_vals got=%0h,%0h exp=5,7", val1, val2); end
    checks++; if (rob_pos !== 4'd3 || opcode !== OPCODE_ARITH || pc !== 32'h1003) begin
      failures++; $display("FAIL add_payload got rob=%0h op=%0h pc=%0h exp rob=3 op=33 pc=1003", rob_pos, opcode, pc); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL add_full got=%0h exp=0", full); end
    tick();
    checks++; if (alu_en !== 1'b0 || val1 !== 32'd5) begin
      failures++; $display("FAIL add_after got en=%0h val1=%0h exp en=0 val1=5", alu_en, val1); end
  endtask

  task automatic test_wakeup();
    // SUB waiting on tag 2; a broadcast for tag 3 must not wake it.
    disp(3'b000, 1'b1, 1'b0, 32'd0, 4'd2, 1'b1, 32'd3, 4'd0, 4'd4);
    tick(); idle();
    alu_result = 1'b1; alu_result_rob_pos = 4'd3; alu_result_val = 32'hEE;
    tick(); idle(); tick();
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL wrong_tag got=%0h exp=0", alu_en); end
    alu_result = 1'b1; alu_result_rob_pos = 4'd2; alu_result_val = 32'h10;
    tick(); idle();
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL wake_same_edge got=%0h exp=0", alu_en); end
    tick();
    checks++; if (alu_en !== 1'b1 || val1 !== 32'h10 || val2 !== 32'd3 || funct7 !== 1'b1 || rob_pos !== 4'd4) begin
      failures++; $display("FAIL sub_wake got en=%0h v1=%0h v2=%0h f7=%0h rob=%0h exp 1,10,3,1,4",
                           alu_en, val1, val2, funct7, rob_pos); end
    // Both broadcasts hit a waiting rs2: ALU value wins.
    disp(3'b000, 1'b0, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd8, 4'd9);
    tick(); idle();
    alu_result = 1'b1; alu_result_rob_pos = 4'd8; alu_result_val = 32'hA1;
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd8; lsb_result_val = 32'hB2;
    tick(); idle(); tick();
    checks++; if (alu_en !== 1'b1 || val2 !== 32'hA1 || rob_pos !== 4'd9) begin
      failures++; $display("FAIL wake_tie got en=%0h v2=%0h rob=%0h exp 1,a1,9", alu_en, val2, rob_pos); end
    tick();
  endtask

  task automatic test_bypass();
    disp(3'b000, 1'b0, 1'b1, 32'h20, 4'd0, 1'b0, 32'd0, 4'd6, 4'd7);
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd6; lsb_result_val = 32'hAB;
    tick(); idle(); tick();
    checks++; if (alu_en !== 1'b1 || val2 !== 32'hAB || val1 !== 32'h20 || rob_pos !== 4'd7) begin
      failures++; $display("FAIL bypass_lsb got en=%0h v1=%0h v2=%0h rob=%0h exp 1,20,ab,7", alu_en, val1, val2, rob_pos); end
    disp(3'b000, 1'b0, 1'b0, 32'd0, 4'd9, 1'b1, 32'd1, 4'd0, 4'd10);
    alu_result = 1'b1; alu_result_rob_pos = 4'd9; alu_result_val = 32'h1111;
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd9; lsb_result_val = 32'h2222;
    tick(); idle(); tick();
    checks++; if (alu_en !== 1'b1 || val1 !== 32'h1111 || rob_pos !== 4'd10) begin
      failures++; $display("FAIL bypass_tie got en=%0h v1=%0h rob=%0h exp 1,1111,a", alu_en, val1, rob_pos); end
    tick();
  endtask

  task automatic test_fill_priority();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      disp(3'b000, 1'b0, 1'b0, 32'd0, 4'(i), 1'b1, 32'(i), 4'd0, 4'(i));
      tick();
      if (i == 13) begin
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_at_14 got=%0h exp=0", full); end
      end
    end
    idle();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_at_15 got=%0h exp=1", full); end
    alu_result = 1'b1; alu_result_rob_pos = 4'd4; alu_result_val = 32'h400;
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd9; lsb_result_val = 32'h900;
    tick(); idle();
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL fill_wake_edge got=%0h exp=0", alu_en); end
    tick();
    checks++; if (alu_en !== 1'b1 || rob_pos !== 4'd4 || val1 !== 32'h400 || full !== 1'b0) begin
      failures++; $display("FAIL prio_first got en=%0h rob=%0h v1=%0h full=%0h exp 1,4,400,0", alu_en, rob_pos, val1, full); end
    tick();
    checks++; if (alu_en !== 1'b1 || rob_pos !== 4'd9 || val1 !== 32'h900 || val2 !== 32'd9) begin
      failures++; $display("FAIL prio_second got en=%0h rob=%0h v1=%0h v2=%0h exp 1,9,900,9", alu_en, rob_pos, val1, val2); end
    tick();
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL prio_drain got=%0h exp=0", alu_en); end
  endtask

  task automatic test_rollback();
    do_reset();
    disp(3'b000, 1'b0, 1'b1, 32'h77, 4'd0, 1'b1, 32'd1, 4'd0, 4'd10);
    tick();
    for (int i = 0; i < 8; i++) begin
      disp(3'b000, 1'b0, 1'b0, 32'd0, 4'(i), 1'b1, 32'd2, 4'd0, 4'(i));
      tick();
    end
    idle();
    checks++; if (val1 !== 32'h77 || rob_pos !== 4'd10) begin
      failures++; $display("FAIL rb_pre_issue got v1=%0h rob=%0h exp 77,a", val1, rob_pos); end
    // Wake tag 0 so an entry is eligible in the rollback cycle.
    alu_result = 1'b1; alu_result_rob_pos = 4'd0; alu_result_val = 32'h55;
    tick(); idle();
    rollback = 1'b1;
    disp(3'b000, 1'b0, 1'b1, 32'h99, 4'd0, 1'b1, 32'h98, 4'd0, 4'd12);
    tick(); idle();
    checks++; if (alu_en !== 1'b0 || full !== 1'b0 || val1 !== 32'd0 || rob_pos !== 4'd0 || pc !== 32'd0) begin
      failures++; $display("FAIL rb_clear got en=%0h full=%0h v1=%0h rob=%0h pc=%0h exp all 0",
                           alu_en, full, val1, rob_pos, pc); end
    for (int k = 1; k < 8; k++) begin
      alu_result = 1'b1; alu_result_rob_pos = 4'(k); alu_result_val = 32'(k);
      tick(); idle();
      checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL rb_no_issue_%0d got=%0h exp=0", k, alu_en); end
    end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    disp(3'b000, 1'b0, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 4'd5);
    tick();
    disp(3'b000, 1'b0, 1'b1, 32'h33, 4'd0, 1'b1, 32'h44, 4'd0, 4'd6);
    tick(); idle();
    checks++; if (alu_en !== 1'b1 || rob_pos !== 4'd5) begin
      failures++; $display("FAIL hold_first got en=%0h rob=%0h exp 1,5", alu_en, rob_pos); end
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (alu_en !== 1'b1 || rob_pos !== 4'd5 || val1 !== 32'h11 || val2 !== 32'h22) begin
        failures++; $display("FAIL hold_%0d got en=%0h rob=%0h v1=%0h v2=%0h exp 1,5,11,22", k, alu_en, rob_pos, val1, val2); end
    end
    rdy = 1'b1;
    tick();
    checks++; if (alu_en !== 1'b1 || rob_pos !== 4'd6 || val1 !== 32'h33) begin
      failures++; $display("FAIL hold_resume got en=%0h rob=%0h v1=%0h exp 1,6,33", alu_en, rob_pos, val1); end
    tick();
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL hold_drain got=%0h exp=0", alu_en); end
  endtask

  initial begin
    idle();
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_bypass();
    test_fill_priority();
    test_rollback();
    test_rdy_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
